// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads 16-bit words from instruction RAM, hands each
// to the CPU with load/start strobes, and waits for the CPU to finish it.
module fetch_sequencer #(
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [2:0]  HALT_OP = 3'b111
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_rdata,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  input  logic          cpu_w,
  output logic [AW-1:0] pc,
  output logic [15:0]   instr_count,
  output logic          busy,
  output logic          halted,
  output logic          fault
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, MEMWAIT, LOADIR, START, EXEC, HALT, FAULT
  } state_t;

  state_t        state, next_state;
  logic [TW-1:0] tcount;
  logic          is_halt_op;
  logic          done;
  logic          expire;

  assign is_halt_op = (cpu_in[15:13] == HALT_OP);
  // The first EXEC cycle (tcount==0) ignores cpu_w: the CPU only drops w one cycle after s.
  assign done       = (state == EXEC) && (tcount != '0) && cpu_w;
  assign expire     = (state == EXEC) && !done && (tcount == TW'(TIMEOUT - 1));
  assign mem_addr   = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (run) next_state = FETCH;
      FETCH:   next_state = MEMWAIT;
      MEMWAIT: next_state = LOADIR;
      LOADIR:  next_state = is_halt_op ? HALT : START;
      START:   next_state = EXEC;
      EXEC: begin
        if (done)        next_state = run ? FETCH : IDLE;
        else if (expire) next_state = FAULT;
      end
      HALT:    next_state = HALT;
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_rd   = (state == FETCH);
    cpu_load = (state == LOADIR) && !is_halt_op;
    cpu_s    = (state == START);
    busy     = !(state == IDLE || state == HALT || state == FAULT);
    halted   = (state == HALT);
    fault    = (state == FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      instr_count <= '0;
      cpu_in      <= '0;
      tcount      <= '0;
    end else begin
      if (state == MEMWAIT) cpu_in <= mem_rdata;
      if (state == START)   tcount <= '0;
      else if (state == EXEC) tcount <= tcount + 1'b1;
      if (done) begin
        pc <= pc + 1'b1;
        if (instr_count != '1) instr_count <= instr_count + 1'b1;
      end
    end
  end

endmodule
